// File: rtl/seq_divider.sv
// Sequential 8-bit restoring divider: operands arrive over one shared data_in
// port on two consecutive cycles, quotient and remainder leave over data_out.
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       q_out,
    output logic       r_out,
    output logic       done,
    output logic       busy,
    output logic       div_zero
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_B = 3'd1;
    localparam logic [2:0] ITER   = 3'd2;
    localparam logic [2:0] RSLT1  = 3'd3;
    localparam logic [2:0] RSLT2  = 3'd4;

    logic [2:0] state;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic [2:0] cnt;

    // One restoring step. R is always below B, so s stays under 2*B and the
    // 9-bit difference never wraps; its top bit is the sign.
    logic [8:0] s;
    logic [8:0] t;

    always_comb begin
        s = {r, q[7]};
        t = s - {1'b0, b};
    end

    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values, whatever order the statements are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a        <= 8'd0;
            b        <= 8'd0;
            q        <= 8'd0;
            r        <= 8'd0;
            cnt      <= 3'd0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a        <= data_in;
                        r        <= 8'd0;
                        q        <= 8'd0;
                        div_zero <= 1'b0;
                        state    <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    b <= data_in;
                    if (data_in != 8'd0) begin
                        q     <= a;
                        cnt   <= 3'd0;
                        state <= ITER;
                    end else begin
                        q        <= 8'hFF;
                        r        <= a;
                        div_zero <= 1'b1;
                        state    <= RSLT1;
                    end
                end
                ITER: begin
                    if (!t[8]) begin
                        r <= t[7:0];
                        q <= {q[6:0], 1'b1};
                    end else begin
                        r <= s[7:0];
                        q <= {q[6:0], 1'b0};
                    end
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= RSLT1;
                    end
                end
                RSLT1:   state <= RSLT2;
                RSLT2:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch forms.
    always_comb begin
        data_out = 8'd0;
        q_out    = 1'b0;
        r_out    = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                done = 1'b1;
                busy = 1'b0;
            end
            RSLT1: begin
                data_out = q;
                q_out    = 1'b1;
            end
            RSLT2: begin
                data_out = r;
                r_out    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: fixed operand pairs with hand-computed
// quotient/remainder, exact-cycle latency, back-to-back and reset abort.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       q_out;
    logic       r_out;
    logic       done;
    logic       busy;
    logic       div_zero;

    int n_checks = 0;
    int n_passed = 0;

    seq_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .q_out    (q_out),
        .r_out    (r_out),
        .done     (done),
        .busy     (busy),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after an edge with the DUT in IDLE; the start is accepted
    // on the next edge, so RSLT1 shows up 10 edges later (2 for a zero divisor).
    task automatic do_div(input logic [7:0] dividend, input logic [7:0] divisor,
                          input logic [7:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_dz, input logic noise);
        start   = 1'b1;
        data_in = dividend;
        step();
        check("busy_after_start", {7'd0, busy}, 8'd1);
        check("dz_cleared_by_start", {7'd0, div_zero}, 8'd0);
        start   = 1'b0;
        data_in = divisor;
        step();
        if (divisor != 8'd0) begin
            for (int i = 0; i < 8; i++) begin
                if (noise) begin
                    start   = 1'($urandom_range(0, 1));
                    data_in = 8'($urandom);
                end
                if (i == 7) check("no_early_q", {7'd0, q_out}, 8'd0);
                step();
            end
            start = 1'b0;
        end
        check("q_strobe", {7'd0, q_out}, 8'd1);
        check("quotient", data_out, exp_q);
        check("dz_flag", {7'd0, div_zero}, {7'd0, exp_dz});
        step();
        check("r_strobe", {7'd0, r_out}, 8'd1);
        check("remainder", data_out, exp_r);
        step();
        check("done_after", {7'd0, done}, 8'd1);
        check("dz_held", {7'd0, div_zero}, {7'd0, exp_dz});
        check("idle_data_out", data_out, 8'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b1;
        data_in = 8'd77;
        step();
        step();
        check("rst_done", {7'd0, done}, 8'd1);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_q_out", {7'd0, q_out}, 8'd0);
        check("rst_r_out", {7'd0, r_out}, 8'd0);
        check("rst_data_out", data_out, 8'd0);
        check("rst_div_zero", {7'd0, div_zero}, 8'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("idle_hold", {7'd0, done}, 8'd1);

        do_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
        do_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0);
        do_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0);
        do_div(8'd200, 8'd0, 8'hFF, 8'd200, 1'b1, 1'b0);
        do_div(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 1'b1);

        // Back-to-back with start held high: 100/7 then 50/5.
        start   = 1'b1;
        data_in = 8'd100;
        step();
        data_in = 8'd7;
        step();
        repeat (8) step();
        check("b2b_q1_strobe", {7'd0, q_out}, 8'd1);
        check("b2b_q1", data_out, 8'd14);
        data_in = 8'd50;
        step();
        check("b2b_r1", data_out, 8'd2);
        step();
        check("b2b_one_idle", {7'd0, done}, 8'd1);
        step();
        check("b2b_restart", {7'd0, busy}, 8'd1);
        data_in = 8'd5;
        step();
        repeat (8) step();
        check("b2b_q2_strobe_at_12", {7'd0, q_out}, 8'd1);
        check("b2b_q2", data_out, 8'd10);
        step();
        check("b2b_r2_strobe_at_13", {7'd0, r_out}, 8'd1);
        check("b2b_r2", data_out, 8'd0);
        start = 1'b0;
        step();
        check("b2b_end_idle", {7'd0, done}, 8'd1);

        // Reset sampled during the 4th ITER cycle aborts the division.
        start   = 1'b1;
        data_in = 8'd100;
        step();
        start   = 1'b0;
        data_in = 8'd7;
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_done", {7'd0, done}, 8'd1);
        check("abort_data_out", data_out, 8'd0);
        check("abort_no_q", {7'd0, q_out}, 8'd0);
        check("abort_no_r", {7'd0, r_out}, 8'd0);
        rst = 1'b0;
        do_div(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
